alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative RV32M multiply/divide unit that runs beside `alu` in the execute stage. It accepts one operation at a time through a start/busy handshake and computes it over several cycles using one shared add/subtract datapath. It returns a registered result with a one-cycle done pulse, and the hazard unit uses `o_busy_EX` to stall the pipeline. Operand width is a parameter; operation codes are the RV32M funct3 values.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 8.
- `CNT_W`, `$clog2(WIDTH)`: iteration counter width; derived, not overridden.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_start_EX`  in  1  request; accepted on an edge where `i_start_EX & ~o_busy_EX & ~i_flush_EX`.
- `i_flush_EX`  in  1  abort any operation in flight.
- `i_muldiv_op_EX`  in  3  operation (funct3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `i_rd1_EX`  in  WIDTH  rs1 operand; sampled at acceptance only.
- `i_rd2_EX`  in  WIDTH  rs2 operand; sampled at acceptance only.
- `o_busy_EX`  out  1  high while in CALC.
- `o_done_EX`  out  1  one-cycle pulse; the result is valid in this cycle.
- `o_result_EX`  out  WIDTH  registered result; held until the next `o_done_EX`.

## Operation
- **States.** IDLE, CALC, DONE. Reset: state IDLE; counter 0; all outputs 0.
- **IDLE/DONE + accept, normal case.** Latch operand magnitudes, result-sign and op, load counter = WIDTH-1, go to CALC.
- **IDLE/DONE + accept, special case.** Go straight to DONE with the fixed result:
  - Divide by zero (rd2 = 0): DIV/DIVU → all ones; REM/REMU → rd1.
  - Signed overflow (DIV/REM, rd1 = 2^(WIDTH-1), rd2 = all ones): DIV → rd1; REM → 0.
- **IDLE/DONE, no accept.** DONE → IDLE.
- **Signed handling.**
  - MUL*: signed operands (per op: MULH both, MULHSU rs1 only) are converted to magnitudes; the product is negated if the signs differ.
  - DIV: quotient is negated if the signs differ.
  - REM: remainder takes the sign of rs1.
  - Sign correction is applied on the CALC→DONE edge.
- **CALC, multiply.** Shift-add on a 2·WIDTH accumulator, one bit per cycle. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- **CALC, divide.** Restoring division, one quotient bit per cycle. The remainder is WIDTH+1 bits; the trial subtract is done with `adder` (cin = 1, b inverted).
- **CALC, stepping.** Counter decrements each cycle. When counter = 0, go to DONE and write `o_result_EX`.
- **Flush.** `i_flush_EX` high forces IDLE on the next edge from any state.
  - No `o_done_EX` is produced for the aborted operation, and `o_result_EX` keeps its old value.
  - Flush beats a simultaneous start.
- **Illegal states.** Unreachable encodings recover to IDLE.

## Timing
- Acceptance edge = E0.
- Iterative latency: CALC for WIDTH cycles; `o_done_EX` is high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after E0 (33 at WIDTH = 32).
- Special-case latency: `o_done_EX` is high in the cycle after E0.
- `o_busy_EX` rises after E0 (iterative only) and falls in the DONE cycle.
- Back-to-back: a start accepted during DONE gives zero idle cycles between operations.
- Asynchronous reset mid-CALC: immediate IDLE, outputs 0, no done pulse.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN`
  - Defined: MUL* ops use a single-cycle combinational 2·WIDTH multiply and go straight to DONE, so `o_done_EX` is high the cycle after E0 and `o_busy_EX` never rises for multiplies.
  - Undefined: multiplies use the iterative WIDTH-cycle path.
  - Divide behaviour is identical either way.

## Structure
- Shared package `alu_pkg`:
  - funct3 op localparams (MUL = 3'b000 … REMU = 3'b111).
  - State encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2).
  - Alongside the existing `alu` control codes.
- Sub-module: the existing `adder`, instantiated at WIDTH+1 for the shared add/subtract step. No other sub-modules.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) → `o_result_EX` = 0xFFFFFFEB; `o_done_EX` 33 cycles after E0; busy high for 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV x / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with done after 1 cycle; DIV 0x80000000 / -1 → 0x80000000, REM → 0.
- Flush at cycle 10 of a DIV, with a new start in the same cycle → no done and the start is ignored; a following MUL 3 × 4 returns 12.
- Start during DONE → next done exactly WIDTH+1 cycles later; `i_rst_n` low mid-CALC → outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: base ALU control codes, RV32M funct3 codes and
// the multiply/divide sequencer state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/adder.sv
// Ripple-style parameterised adder with carry in/out.
module adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit sharing one WIDTH+1 adder.
// Define ALU_MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_EX,
  input  logic             i_flush_EX,
  input  logic [2:0]       i_muldiv_op_EX,
  input  logic [WIDTH-1:0] i_rd1_EX,
  input  logic [WIDTH-1:0] i_rd2_EX,
  output logic             o_busy_EX,
  output logic             o_done_EX,
  output logic [WIDTH-1:0] o_result_EX
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_opb;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [WIDTH-1:0]  r_result;

  logic              w_accept, w_accept_ok;
  logic              w_op_mul, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_res_neg;
  logic [WIDTH-1:0]  w_mag_a, w_mag_b;
  logic              w_div_zero, w_div_ovf, w_special;
  logic [WIDTH-1:0]  w_special_res;
  logic              w_fast;
  logic [WIDTH-1:0]  w_fast_res;

  assign w_accept    = i_start_EX & ~o_busy_EX & ~i_flush_EX;
  assign w_accept_ok = w_accept & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  assign w_op_mul   = ~i_muldiv_op_EX[2];
  assign w_a_signed = (i_muldiv_op_EX == OP_MULH) | (i_muldiv_op_EX == OP_MULHSU) |
                      (i_muldiv_op_EX == OP_DIV)  | (i_muldiv_op_EX == OP_REM);
  assign w_b_signed = (i_muldiv_op_EX == OP_MULH) | (i_muldiv_op_EX == OP_DIV) |
                      (i_muldiv_op_EX == OP_REM);
  assign w_a_neg    = w_a_signed & i_rd1_EX[WIDTH-1];
  assign w_b_neg    = w_b_signed & i_rd2_EX[WIDTH-1];
  assign w_mag_a    = w_a_neg ? -i_rd1_EX : i_rd1_EX;
  assign w_mag_b    = w_b_neg ? -i_rd2_EX : i_rd2_EX;
  // Remainder follows the dividend sign; everything else uses the xor of signs.
  assign w_res_neg  = (i_muldiv_op_EX == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = i_muldiv_op_EX[2] & (i_rd2_EX == '0);
  assign w_div_ovf  = ((i_muldiv_op_EX == OP_DIV) | (i_muldiv_op_EX == OP_REM)) &
                      (i_rd1_EX == MIN_NEG) & (i_rd2_EX == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = i_muldiv_op_EX[1] ? i_rd1_EX : '1;
    else if (w_div_ovf)
      w_special_res = i_muldiv_op_EX[1] ? '0 : i_rd1_EX;
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_mag, w_fast_prod;
  assign w_fast_mag  = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
  assign w_fast_prod = w_res_neg ? -w_fast_mag : w_fast_mag;
  assign w_fast      = w_op_mul;
  assign w_fast_res  = (i_muldiv_op_EX == OP_MUL) ? w_fast_prod[WIDTH-1:0]
                                                  : w_fast_prod[2*WIDTH-1:WIDTH];
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = '0;
`endif

  // Shared step: multiply adds the multiplicand into the high half,
  // divide trial-subtracts the divisor from the shifted partial remainder.
  logic              w_calc_mul;
  logic [WIDTH:0]    w_add_a, w_add_b, w_sum;
  logic              w_cout;
  logic [WIDTH-1:0]  w_rem_nxt, w_lo_nxt;

  assign w_calc_mul = ~r_op[2];
  assign w_add_a    = w_calc_mul ? {1'b0, r_rem} : {r_rem, r_lo[WIDTH-1]};
  assign w_add_b    = w_calc_mul ? (r_lo[0] ? {1'b0, r_opb} : '0) : ~{1'b0, r_opb};

  adder #(.WIDTH(WIDTH + 1)) u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (~w_calc_mul),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    if (w_calc_mul) begin
      w_rem_nxt = w_sum[WIDTH:1];
      w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_rem_nxt = w_cout ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0];
      w_lo_nxt  = {r_lo[WIDTH-2:0], w_cout};
    end
  end

  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_div_val, w_div_s, w_final;

  assign w_prod    = {w_rem_nxt, w_lo_nxt};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_div_val = r_op[1] ? w_rem_nxt : w_lo_nxt;
  assign w_div_s   = r_neg ? -w_div_val : w_div_val;
  assign w_final   = r_op[2] ? w_div_s :
                     (r_op == OP_MUL) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_nxt = (w_special | w_fast) ? ST_DONE : ST_CALC;
        else          w_state_nxt = ST_IDLE;
      end
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_flush_EX) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (i_flush_EX) begin
      r_cnt <= '0;
    end else if (w_accept_ok) begin
      if (w_special) begin
        r_result <= w_special_res;
      end else if (w_fast) begin
        r_result <= w_fast_res;
      end else begin
        r_cnt <= CNT_W'(WIDTH - 1);
        r_rem <= '0;
        r_lo  <= w_mag_a;
        r_opb <= w_mag_b;
        r_op  <= i_muldiv_op_EX;
        r_neg <= w_res_neg;
      end
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      r_rem <= w_rem_nxt;
      r_lo  <= w_lo_nxt;
      if (r_cnt == '0) r_result <= w_final;
    end
  end

  assign o_busy_EX   = (r_state == ST_CALC);
  assign o_done_EX   = (r_state == ST_DONE);
  assign o_result_EX = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv against an arithmetic
// reference model of the RV32M multiply/divide rules.
module tb_alu_muldiv;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] rd1, rd2;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start_EX     (start),
    .i_flush_EX     (flush),
    .i_muldiv_op_EX (op),
    .i_rd1_EX       (rd1),
    .i_rd2_EX       (rd2),
    .o_busy_EX      (busy),
    .o_done_EX      (done),
    .o_result_EX    (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          ia = $signed(a);
    int          ib = $signed(b);
    longint      sa = longint'(ia);
    longint      sb = longint'(ib);
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      MUL:     begin p = 64'(ua * ub); return p[31:0];  end
      MULH:    begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU:  begin p = 64'(sa * ub); return p[63:32]; end
      MULHU:   begin p = 64'(ua * ub); return p[63:32]; end
      DIV:     return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return FAST ? 1 : 33;
    if (b == 0) return 1;
    if ((f == DIV || f == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    op = f; rd1 = a; rd2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat, busy_n, elat;
    logic [31:0] exp;
    exp  = ref_op(f, a, b);
    elat = ref_lat(f, a, b);
    @(negedge clk);
    issue(f, a, b);
    wait_done(lat, busy_n);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_busy"}, 32'(busy_n), (elat == 33) ? 32'd32 : 32'd0);
    last_exp = exp;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int lat, busy_n, dn;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; rd1 = '0; rd2 = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul_7x-3", MUL, 32'd7, 32'hFFFF_FFFD);
    do_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulh_neg", MULH, 32'h8000_0000, 32'h8000_0000);
    do_op("div_-7_2", DIV, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_-7_2", REM, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_100_7", DIVU, 32'd100, 32'd7);
    do_op("remu_100_7", REMU, 32'd100, 32'd7);
    do_op("div_by0", DIV, 32'd1234, 32'd0);
    do_op("rem_5_0", REM, 32'd5, 32'd0);
    do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush mid-divide with a competing start in the same cycle
    @(negedge clk);
    issue(DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = MUL; rd1 = 32'd5; rd2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("flush_nodone", 32'(dn), 32'd0);
    check("flush_keep", result, last_exp);
    do_op("mul_3x4", MUL, 32'd3, 32'd4);

    // Back-to-back: second start issued in the DONE cycle of the first
    @(negedge clk);
    issue(DIVU, 32'd5000, 32'd9);
    wait_done(lat, busy_n);
    check("b2b_res1", result, ref_op(DIVU, 32'd5000, 32'd9));
    issue(REM, 32'hFFFF_F000, 32'd77);
    wait_done(lat, busy_n);
    check("b2b_res2", result, ref_op(REM, 32'hFFFF_F000, 32'd77));
    check("b2b_lat", 32'(lat), 32'd33);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      do_op($sformatf("rnd%0d_op%0d", n, f), f, rnd_operand(), rnd_operand());
    end

    // Asynchronous reset in the middle of an iterative divide
    @(negedge clk);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", MULHU, 32'h1234_5678, 32'h9ABC_DEF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
